// File: rtl/frame_capture_write_ctrl.sv
// Raster capture: packs 4 pixels per word and writes one frame into FRAMEMEM.
// Optional FRAME_CAP_CHECKSUM_EN adds a per-frame pixel checksum and an hsync-inside-de check.
module frame_capture_write_ctrl #(
    parameter int unsigned HRES       = 320,
    parameter int unsigned VRES       = 240,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned MEM_WIDTH  = DATA_WIDTH * 4,
    parameter int unsigned ADDR_DEPTH = HRES * VRES / 4,
    parameter int unsigned ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  rst_n,
    input  logic                  i_capture_en,
    input  logic                  i_vsync,
    input  logic                  i_hsync,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_fmem_csn,
    output logic                  o_fmem_wen,
    output logic [ADDR_WIDTH-1:0] o_fmem_addr,
    output logic [MEM_WIDTH-1:0]  o_fmem_din,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_err,
    output logic [31:0]           o_frame_sum
);

    localparam int unsigned PIX_W  = $clog2(HRES + 2);
    localparam int unsigned LINE_W = $clog2(VRES + 1);
    localparam int unsigned WC_W   = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

    state_t                state;
    logic                  vsync_d;
    logic                  de_d;
    logic [MEM_WIDTH-1:0]  pack;
    logic [1:0]            pack_idx;
    logic [PIX_W-1:0]      pix_cnt;
    logic [LINE_W-1:0]     line_cnt;
    logic [WC_W-1:0]       word_cnt;

    logic                  vs_rise;
    logic                  de_fall;
    logic                  line_last;
    logic                  frame_end;
    logic                  restart_err;
    logic                  frame_start;
    logic                  wr_req;
    logic [MEM_WIDTH-1:0]  wr_word;

`ifdef FRAME_CAP_CHECKSUM_EN
    logic                  hsync_d;
    logic [31:0]           sum_acc;
`else
    logic                  unused_hsync;
    assign unused_hsync = i_hsync;
    assign o_frame_sum  = 32'd0;
`endif

    // Event decode; a vsync coinciding with the last line's de_fall completes the frame instead of aborting it
    always_comb begin
        vs_rise     = i_vsync & ~vsync_d;
        de_fall     = ~i_de & de_d;
        line_last   = (line_cnt == LINE_W'(VRES - 1));
        frame_end   = (state == CAPTURE) && de_fall && line_last;
        restart_err = (state == CAPTURE) && vs_rise && !(de_fall && line_last);
        frame_start = ((state == WAIT_VS) && i_capture_en && vs_rise) || restart_err ||
                      (frame_end && vs_rise && i_capture_en);
        wr_req      = 1'b0;
        wr_word     = pack;
        if ((state == CAPTURE) && !restart_err) begin
            if (i_de && (pack_idx == 2'd3)) begin
                wr_req  = 1'b1;
                wr_word = {i_data, pack[3*DATA_WIDTH-1:0]};
            end else if (de_fall && (pack_idx != 2'd0)) begin
                wr_req  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vsync_d      <= 1'b0;
            de_d         <= 1'b0;
            pack         <= '0;
            pack_idx     <= 2'd0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            word_cnt     <= '0;
            o_fmem_csn   <= 1'b1;
            o_fmem_wen   <= 1'b1;
            o_fmem_addr  <= '0;
            o_fmem_din   <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
`ifdef FRAME_CAP_CHECKSUM_EN
            hsync_d      <= 1'b0;
            sum_acc      <= 32'd0;
            o_frame_sum  <= 32'd0;
`endif
        end else begin
            vsync_d      <= i_vsync;
            de_d         <= i_de;
            o_fmem_csn   <= 1'b1;
            o_fmem_wen   <= 1'b1;
            o_frame_done <= 1'b0;
`ifdef FRAME_CAP_CHECKSUM_EN
            hsync_d      <= i_hsync;
`endif
            // Memory write; the word counter saturates at depth and further writes are dropped
            if (wr_req) begin
                if (word_cnt == WC_W'(ADDR_DEPTH)) begin
                    o_err <= 1'b1;
                end else begin
                    o_fmem_csn  <= 1'b0;
                    o_fmem_wen  <= 1'b0;
                    o_fmem_addr <= word_cnt[ADDR_WIDTH-1:0];
                    o_fmem_din  <= wr_word;
                    word_cnt    <= word_cnt + WC_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (i_capture_en) state <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (!i_capture_en) state <= IDLE;
                end
                CAPTURE: begin
                    if (!restart_err) begin
                        if (i_de) begin
                            if (pack_idx == 2'd3) pack <= '0;
                            else pack[pack_idx*DATA_WIDTH +: DATA_WIDTH] <= i_data;
                            pack_idx <= pack_idx + 2'd1;
                            if (pix_cnt != PIX_W'(HRES + 1)) pix_cnt <= pix_cnt + PIX_W'(1);
`ifdef FRAME_CAP_CHECKSUM_EN
                            sum_acc <= sum_acc + 32'(i_data);
                            if (i_hsync && !hsync_d) o_err <= 1'b1;
`endif
                        end
                        if (de_fall) begin
                            line_cnt <= line_cnt + LINE_W'(1);
                            if ((pix_cnt != PIX_W'(HRES)) || (pack_idx != 2'd0)) o_err <= 1'b1;
                            pix_cnt  <= '0;
                            pack_idx <= 2'd0;
                            pack     <= '0;
                        end
                        if (frame_end) begin
                            o_frame_done <= 1'b1;
`ifdef FRAME_CAP_CHECKSUM_EN
                            o_frame_sum  <= sum_acc;
`endif
                            state  <= i_capture_en ? WAIT_VS : IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Frame (re)start overrides the per-cycle updates above
            if (frame_start) begin
                state    <= CAPTURE;
                o_busy   <= 1'b1;
                o_err    <= restart_err;
                word_cnt <= '0;
                pix_cnt  <= '0;
                line_cnt <= '0;
                pack_idx <= 2'd0;
                pack     <= '0;
`ifdef FRAME_CAP_CHECKSUM_EN
                sum_acc  <= 32'd0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_frame_capture_write_ctrl.sv
// Directed bench for frame_capture_write_ctrl at 8x2 resolution with a write scoreboard.
module tb_frame_capture_write_ctrl;

    localparam int unsigned HRES = 8;
    localparam int unsigned VRES = 2;
    localparam int unsigned DW   = 24;
    localparam int unsigned MW   = 96;
    localparam int unsigned AW   = 2;

    logic          i_clk;
    logic          rst_n;
    logic          i_capture_en;
    logic          i_vsync;
    logic          i_hsync;
    logic          i_de;
    logic [DW-1:0] i_data;
    logic          o_fmem_csn;
    logic          o_fmem_wen;
    logic [AW-1:0] o_fmem_addr;
    logic [MW-1:0] o_fmem_din;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_err;
    logic [31:0]   o_frame_sum;

    frame_capture_write_ctrl #(.HRES(HRES), .VRES(VRES), .DATA_WIDTH(DW)) dut (
        .i_clk(i_clk), .rst_n(rst_n), .i_capture_en(i_capture_en),
        .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de), .i_data(i_data),
        .o_fmem_csn(o_fmem_csn), .o_fmem_wen(o_fmem_wen), .o_fmem_addr(o_fmem_addr),
        .o_fmem_din(o_fmem_din), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_err(o_err), .o_frame_sum(o_frame_sum)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [MW-1:0] din;
    } wr_t;

    wr_t         exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [DW-1:0] slots[4];
    int          nslot = 0;
    int          m_addr = 0;
    logic [31:0] m_sum = 32'd0;
    bit          model_on = 1'b0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic push_word();
        wr_t e;
        e.addr = AW'(m_addr);
        e.din  = '0;
        for (int k = 0; k < nslot; k++) e.din[k*DW +: DW] = slots[k];
        exp_q.push_back(e);
        m_addr++;
        nslot = 0;
    endtask

    task automatic add_pix(input logic [DW-1:0] p);
        slots[nslot] = p;
        nslot++;
        m_sum = m_sum + 32'(p);
        if (nslot == 4) push_word();
    endtask

    task automatic send_line(input int npix, input int first);
        for (int i = 0; i < npix; i++) begin
            i_de   = 1'b1;
            i_data = DW'(first + i);
            if (model_on) add_pix(DW'(first + i));
            tick(1);
        end
        i_de = 1'b0;
        if (model_on && nslot != 0) push_word();
        tick(2);
        i_hsync = 1'b1;
        tick(1);
        i_hsync = 1'b0;
        tick(3);
    endtask

    task automatic vs_pulse();
        model_on = i_capture_en;
        if (model_on) begin
            m_addr = 0;
            nslot  = 0;
            m_sum  = 32'd0;
        end
        i_vsync = 1'b1;
        tick(1);
        i_vsync = 1'b0;
        tick(2);
    endtask

    function automatic logic [31:0] exp_sum();
`ifdef FRAME_CAP_CHECKSUM_EN
        return m_sum;
`else
        return 32'd0;
`endif
    endfunction

    // Scoreboard: every write cycle pops the oldest predicted word
    always @(negedge i_clk) begin
        if (rst_n) begin
            if (!o_fmem_csn) begin
                wr_t e;
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious_write_csn", 128'(o_fmem_csn), 128'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 128'(o_fmem_addr), 128'(e.addr));
                    check("wr_din", 128'(o_fmem_din), 128'(e.din));
                    check("wr_wen", 128'(o_fmem_wen), 128'd0);
                end
            end
            if (o_frame_done) done_cnt++;
        end
    end

    initial begin
        rst_n = 1'b1; i_capture_en = 1'b0; i_vsync = 1'b0; i_hsync = 1'b0;
        i_de = 1'b0; i_data = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_csn", 128'(o_fmem_csn), 128'd1);
        check("rst_wen", 128'(o_fmem_wen), 128'd1);
        check("rst_addr", 128'(o_fmem_addr), 128'd0);
        check("rst_din", 128'(o_fmem_din), 128'd0);
        check("rst_busy", 128'(o_busy), 128'd0);
        check("rst_done", 128'(o_frame_done), 128'd0);
        check("rst_err", 128'(o_err), 128'd0);
        check("rst_sum", 128'(o_frame_sum), 128'd0);
        tick(2);
        #2 rst_n = 1'b1;
        tick(1);

        // Basic frame: pixels 1..16
        i_capture_en = 1'b1;
        tick(2);
        vs_pulse();
        check("f1_busy", 128'(o_busy), 128'd1);
        send_line(8, 1);
        send_line(8, 9);
        check("f1_done_cnt", 128'(done_cnt), 128'd1);
        check("f1_err", 128'(o_err), 128'd0);
        check("f1_busy_after", 128'(o_busy), 128'd0);
        check("f1_sum", 128'(o_frame_sum), 128'(exp_sum()));
        check("f1_wr_cnt", 128'(wr_cnt), 128'd4);

        // Short line: partial word flushed, err sticky to next frame start
        vs_pulse();
        send_line(6, 'h100);
        check("short_line_err", 128'(o_err), 128'd1);
        send_line(8, 'h200);
        check("short_line_done", 128'(done_cnt), 128'd2);
        check("short_line_err_hold", 128'(o_err), 128'd1);
        vs_pulse();
        check("next_frame_err_clr", 128'(o_err), 128'd0);

        // Short frame: vsync after line 1 restarts at address 0
        send_line(8, 'h300);
        vs_pulse();
        check("short_frame_err", 128'(o_err), 128'd1);
        check("short_frame_no_done", 128'(done_cnt), 128'd2);
        send_line(8, 'h400);
        send_line(8, 'h500);
        check("restart_done", 128'(done_cnt), 128'd3);
        check("restart_err_hold", 128'(o_err), 128'd1);
        check("restart_sum", 128'(o_frame_sum), 128'(exp_sum()));

        // Capture disabled at vsync: nothing written
        i_capture_en = 1'b0;
        tick(2);
        vs_pulse();
        check("disabled_busy", 128'(o_busy), 128'd0);
        send_line(8, 'h600);
        check("disabled_wr_cnt", 128'(wr_cnt), 128'd14);

        // Disable mid-frame: frame still completes, then idle
        i_capture_en = 1'b1;
        tick(2);
        vs_pulse();
        send_line(8, 'h700);
        i_capture_en = 1'b0;
        send_line(8, 'h800);
        check("midoff_done", 128'(done_cnt), 128'd4);
        check("midoff_busy", 128'(o_busy), 128'd0);
        check("midoff_sum", 128'(o_frame_sum), 128'(exp_sum()));
        vs_pulse();
        send_line(8, 'h900);
        check("midoff_idle_wr_cnt", 128'(wr_cnt), 128'd18);

        // Reset in the middle of a line: partial word dropped
        i_capture_en = 1'b1;
        tick(2);
        vs_pulse();
        for (int i = 0; i < 6; i++) begin
            i_de   = 1'b1;
            i_data = DW'('hA00 + i);
            add_pix(DW'('hA00 + i));
            tick(1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_csn", 128'(o_fmem_csn), 128'd1);
        check("midrst_din", 128'(o_fmem_din), 128'd0);
        check("midrst_busy", 128'(o_busy), 128'd0);
        check("midrst_err", 128'(o_err), 128'd0);
        i_de = 1'b0;
        nslot = 0;
        model_on = 1'b0;
        tick(2);
        #2 rst_n = 1'b1;
        tick(4);
        check("midrst_busy_after", 128'(o_busy), 128'd0);
        check("total_wr_cnt", 128'(wr_cnt), 128'd19);
        check("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
